// File: rtl/h80cpu_bus_master.sv
`timescale 1ns/1ps
// h80 CPU bus master: turns single core load/store requests into h80 bus cycles,
// splitting misaligned half/long accesses into byte cycles and extending read data.
module h80cpu_bus_master #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int WAIT_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      ack,
  output logic                      err,
  output logic [31:0]               rdata,
  output logic                      busy,
  output logic                      ce_n,
  output logic [BUS_ADDR_WIDTH-1:0] addr,
  output logic [BUS_CMD_WIDTH-1:0]  cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] data_,
  input  logic                      wait_n
);

  // Bus command encoding: cmd[2:1] selects width, cmd[0]=1 marks a read.
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE   = BUS_CMD_WIDTH'(3'b000);
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ    = BUS_CMD_WIDTH'(3'b001);
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE_B = BUS_CMD_WIDTH'(3'b010);
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ_B  = BUS_CMD_WIDTH'(3'b011);
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE_H = BUS_CMD_WIDTH'(3'b100);
  localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ_H  = BUS_CMD_WIDTH'(3'b101);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, T1, T2, GAP, DONE} state_t;

  state_t                     state_reg, state_next;
  logic                       we_reg;
  logic [1:0]                 size_reg;
  logic                       signed_reg;
  logic [BUS_ADDR_WIDTH-1:0]  base_reg;
  logic [31:0]                wdata_reg;
  logic                       split_reg;
  logic [1:0]                 sub_reg;
  logic [1:0]                 last_reg;
  logic [CNT_W-1:0]           wait_cnt_reg;
  logic [31:0]                acc_reg;
  logic                       err_reg;
  logic [31:0]                rdata_reg;

  logic                       split_in;
  logic [1:0]                 last_in;
  logic [1:0]                 cyc_size;
  logic [4:0]                 byte_sel;
  logic                       last_sub;
  logic                       timeout_hit;
  logic                       bus_active;
  logic                       drive_data;
  logic [BUS_CMD_WIDTH-1:0]   cyc_cmd;
  logic [31:0]                wr_lane;
  logic [31:0]                acc_cap;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sg);
    case (sz)
      SIZE_BYTE: return sg ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
      SIZE_HALF: return sg ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      default:   return v;
    endcase
  endfunction

  assign split_in = ((req_size == SIZE_HALF) && req_addr[0]) ||
                    ((req_size == SIZE_LONG) && (req_addr[1:0] != 2'b00));
  assign last_in  = split_in ? ((req_size == SIZE_HALF) ? 2'd1 : 2'd3) : 2'd0;

  // A split access always runs byte cycles, byte k of the request in sub-cycle k.
  assign cyc_size    = split_reg ? SIZE_BYTE : size_reg;
  assign byte_sel    = {sub_reg, 3'b000};
  assign last_sub    = (sub_reg == last_reg);
  assign timeout_hit = (WAIT_TIMEOUT > 0) && (wait_cnt_reg == WAIT_LAST);
  assign bus_active  = (state_reg == T1) || (state_reg == T2);
  assign drive_data  = bus_active && we_reg;

  always_comb begin
    cyc_cmd = we_reg ? BUS_CMD_WRITE : BUS_CMD_READ;
    wr_lane = 32'h0;
    acc_cap = acc_reg;
    case (cyc_size)
      SIZE_BYTE: begin
        cyc_cmd      = we_reg ? BUS_CMD_WRITE_B : BUS_CMD_READ_B;
        wr_lane[7:0] = wdata_reg[byte_sel +: 8];
        acc_cap[byte_sel +: 8] = data_[7:0];
      end
      SIZE_HALF: begin
        cyc_cmd       = we_reg ? BUS_CMD_WRITE_H : BUS_CMD_READ_H;
        wr_lane[15:0] = wdata_reg[15:0];
        acc_cap[15:0] = data_[15:0];
      end
      default: begin
        wr_lane = wdata_reg;
        acc_cap = data_[31:0];
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req) state_next = (req_size == SIZE_BAD) ? DONE : T1;
      T1:   state_next = T2;
      T2: begin
        if (wait_n)           state_next = last_sub ? DONE : GAP;
        else if (timeout_hit) state_next = DONE;
      end
      GAP:  state_next = T1;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      size_reg     <= SIZE_LONG;
      signed_reg   <= 1'b0;
      base_reg     <= '0;
      wdata_reg    <= '0;
      split_reg    <= 1'b0;
      sub_reg      <= 2'd0;
      last_reg     <= 2'd0;
      wait_cnt_reg <= '0;
      acc_reg      <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg     <= req_we;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            base_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            split_reg  <= split_in;
            last_reg   <= last_in;
            sub_reg    <= 2'd0;
            acc_reg    <= '0;
            err_reg    <= (req_size == SIZE_BAD);
          end
        end
        T1: wait_cnt_reg <= '0;
        T2: begin
          if (wait_n) begin
            if (!we_reg) acc_reg <= acc_cap;
            if (last_sub) begin
              if (!we_reg) rdata_reg <= extend(acc_cap, size_reg, signed_reg);
            end else begin
              sub_reg <= sub_reg + 2'd1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            // An aborted load returns whatever bytes were gathered, unextended.
            if (timeout_hit) begin
              err_reg <= 1'b1;
              if (!we_reg) rdata_reg <= acc_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_ = drive_data ? wr_lane : {BUS_DATA_WIDTH{1'bz}};
  assign ce_n  = !bus_active;
  assign addr  = base_reg + BUS_ADDR_WIDTH'(sub_reg);
  assign cmd   = cyc_cmd;
  assign ack   = (state_reg == DONE);
  assign err   = (state_reg == DONE) && err_reg;
  assign busy  = (state_reg != IDLE);
  assign rdata = rdata_reg;

endmodule
